sram_arbiter: RTL and testbench

- Round-robin arbiter sharing one single-port SRAM (registered read, sync active-high clear, ADDR_W/DATA_W generic) between two requesters, A and B.
- Grants at most one access per cycle and returns read data with fixed latency.
- Sequences a one-cycle memory clear after reset release.
- Sits between two client engines and the SRAM instance.

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 40 ++++
 rtl/sram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Purpose: shared types and constants for the two-client SRAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
// Optional feature macro used by the top: SRAM_ARB_PERF_EN (per-client grant counters).
package sram_arb_pkg;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} arb_state_t;
    typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

    localparam int PERF_W = 16;

    // Pending-read tag: travels one stage alongside the SRAM's registered read.
    typedef struct packed {
        logic   vld;
        owner_t own;
    } rd_tag_t;

    // Saturating increment for the grant counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-way round-robin grant plus the last-grant register.
// Latency: grant is combinational from valids; last-grant updates at the clock edge.
// Backpressure: grants only while en_i is high; a losing requester simply sees no grant.
// Ports: clk, rst_n (async active-low), en_i, a_vld_i/b_vld_i in; a_gnt_o/b_gnt_o out.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic a_vld_i,
    input  logic b_vld_i,
    output logic a_gnt_o,
    output logic b_gnt_o
);

    owner_t last_q, last_d;

    // On a conflict the requester that was not served last wins.
    always_comb begin
        a_gnt_o = en_i & a_vld_i & (~b_vld_i | (last_q == OWN_B));
        b_gnt_o = en_i & b_vld_i & (~a_vld_i | (last_q == OWN_A));
        last_d  = last_q;
        if (a_gnt_o) begin
            last_d = OWN_A;
        end else if (b_gnt_o) begin
            last_d = OWN_B;
        end
    end

    // Reset to B so that A wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Purpose: shares one single-port registered-read SRAM between requesters A and B, clears it after reset.
// Latency: request handshake combinational; read data 2 cycles after grant (registered rvalid/rdata).
// Backpressure: x_ready is the round-robin grant; responses have no backpressure.
// Ports: clk, rst (async active-low); per client valid/ready/wr/addr/wdata in, rvalid/rdata out;
//        mem_rst/mem_wr/mem_addrs/mem_din to the SRAM, mem_dout from it; busy high during INIT.
// Optional: define SRAM_ARB_PERF_EN to add 16-bit saturating a_grant_cnt/b_grant_cnt outputs.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_rst,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addrs,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] a_grant_cnt,
    output logic [PERF_W-1:0] b_grant_cnt
`endif
);

    arb_state_t        state_q;
    logic              busy_q;
    logic              mem_rst_q;
    logic              a_gnt, b_gnt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    rd_tag_t           tag_q, tag_d;
    logic              a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    // INIT lasts exactly one edge after reset release; that edge clears the SRAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= INIT;
            busy_q    <= 1'b1;
            mem_rst_q <= 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    state_q   <= RUN;
                    busy_q    <= 1'b0;
                    mem_rst_q <= 1'b0;
                end
                default: begin
                    state_q   <= RUN;
                    busy_q    <= 1'b0;
                    mem_rst_q <= 1'b0;
                end
            endcase
        end
    end

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (state_q == RUN),
        .a_vld_i (a_valid),
        .b_vld_i (b_valid),
        .a_gnt_o (a_gnt),
        .b_gnt_o (b_gnt)
    );

    // Idle cycles keep the last address on the bus: a harmless read, no toggling.
    always_comb begin
        mem_wr    = 1'b0;
        mem_addrs = addr_q;
        mem_din   = '0;
        if (a_gnt) begin
            mem_wr    = a_wr;
            mem_addrs = a_addr;
            mem_din   = a_wdata;
        end else if (b_gnt) begin
            mem_wr    = b_wr;
            mem_addrs = b_addr;
            mem_din   = b_wdata;
        end
        addr_d    = mem_addrs;
        tag_d.vld = (a_gnt & ~a_wr) | (b_gnt & ~b_wr);
        tag_d.own = b_gnt ? OWN_B : OWN_A;
    end

    // Tag follows the SRAM read register by one stage; response regs add the second.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            tag_q      <= '{vld: 1'b0, own: OWN_A};
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            a_rvalid_q <= tag_q.vld && (tag_q.own == OWN_A);
            b_rvalid_q <= tag_q.vld && (tag_q.own == OWN_B);
            if (tag_q.vld && (tag_q.own == OWN_A)) begin
                a_rdata_q <= mem_dout;
            end
            if (tag_q.vld && (tag_q.own == OWN_B)) begin
                b_rdata_q <= mem_dout;
            end
        end
    end

    assign a_ready  = a_gnt;
    assign b_ready  = b_gnt;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign busy     = busy_q;
    assign mem_rst  = mem_rst_q;

`ifdef SRAM_ARB_PERF_EN
    logic [PERF_W-1:0] a_cnt_q, b_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            if (a_gnt) a_cnt_q <= sat_inc(a_cnt_q);
            if (b_gnt) b_cnt_q <= sat_inc(b_cnt_q);
        end
    end

    assign a_grant_cnt = a_cnt_q;
    assign b_grant_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Purpose: self-checking bench for sram_arbiter with a behavioural SRAM and a reference model.
// Latency: model expects read data two cycles after the grant cycle.
// Backpressure: clients hold valid and fields until ready; responses are always accepted.
module tb_sram_arbiter;

    localparam int AW = 3;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid = 1'b0, a_wr = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_valid = 1'b0, b_wr = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_ready, a_rvalid, b_ready, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_rst, mem_wr, busy;
    logic [AW-1:0] mem_addrs;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
`ifdef SRAM_ARB_PERF_EN
    logic [15:0]   a_grant_cnt, b_grant_cnt;
`endif

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_wr      (a_wr),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_wr      (b_wr),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .mem_rst   (mem_rst),
        .mem_wr    (mem_wr),
        .mem_addrs (mem_addrs),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .busy      (busy)
`ifdef SRAM_ARB_PERF_EN
        ,
        .a_grant_cnt (a_grant_cnt),
        .b_grant_cnt (b_grant_cnt)
`endif
    );

    // Behavioural single-port SRAM: registered read, synchronous clear.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_rst) begin
            for (int i = 0; i < (1 << AW); i++) sram[i] <= '0;
            mem_dout <= '0;
        end else begin
            if (mem_wr) sram[mem_addrs] <= mem_din;
            mem_dout <= sram[mem_addrs];
        end
    end

    // Reference model state.
    typedef struct {
        int            due;
        bit            own_b;
        logic [DW-1:0] data;
    } rsp_t;

    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    bit            init_cyc;
    bit            last_b;
    bit            auto_mode = 1'b0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] mm [0:(1<<AW)-1];
    logic [DW-1:0] exp_ard, exp_brd;
    int            cnt_a, cnt_b;
    rsp_t          rq [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic rand_a();
        a_valid = ($urandom_range(0, 3) != 0);
        a_wr    = $urandom_range(0, 1);
        a_addr  = $urandom_range(0, (1 << AW) - 1);
        a_wdata = $urandom_range(0, (1 << DW) - 1);
    endtask

    task automatic rand_b();
        b_valid = ($urandom_range(0, 3) != 0);
        b_wr    = $urandom_range(0, 1);
        b_addr  = $urandom_range(0, (1 << AW) - 1);
        b_wdata = $urandom_range(0, (1 << DW) - 1);
    endtask

    // One clock cycle: check at the falling edge, advance the model at the rising edge,
    // then present the next requests just after it.
    task automatic step();
        bit ea, eb, rv_a, rv_b;
        @(negedge clk);
        if (init_cyc) begin
            ea = 1'b0;
            eb = 1'b0;
        end else begin
            ea = a_valid && (!b_valid || last_b);
            eb = b_valid && (!a_valid || !last_b);
        end
        check_eq("a_ready", a_ready, ea);
        check_eq("b_ready", b_ready, eb);
        check_eq("busy", busy, init_cyc);
        check_eq("mem_rst", mem_rst, init_cyc);
        if (ea) begin
            check_eq("mem_wr_a", mem_wr, a_wr);
            check_eq("mem_addrs_a", mem_addrs, a_addr);
            if (a_wr) check_eq("mem_din_a", mem_din, a_wdata);
        end else if (eb) begin
            check_eq("mem_wr_b", mem_wr, b_wr);
            check_eq("mem_addrs_b", mem_addrs, b_addr);
            if (b_wr) check_eq("mem_din_b", mem_din, b_wdata);
        end else begin
            check_eq("mem_wr_idle", mem_wr, 1'b0);
            check_eq("mem_addrs_idle", mem_addrs, last_addr);
        end
        rv_a = 1'b0;
        rv_b = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].own_b) begin
                rv_b    = 1'b1;
                exp_brd = rq[0].data;
            end else begin
                rv_a    = 1'b1;
                exp_ard = rq[0].data;
            end
            void'(rq.pop_front());
        end
        check_eq("a_rvalid", a_rvalid, rv_a);
        check_eq("a_rdata", a_rdata, exp_ard);
        check_eq("b_rvalid", b_rvalid, rv_b);
        check_eq("b_rdata", b_rdata, exp_brd);
`ifdef SRAM_ARB_PERF_EN
        check_eq("a_grant_cnt", a_grant_cnt, cnt_a);
        check_eq("b_grant_cnt", b_grant_cnt, cnt_b);
`endif
        @(posedge clk);
        init_cyc = 1'b0;
        if (ea) begin
            if (a_wr) mm[a_addr] = a_wdata;
            else rq.push_back('{due: cyc + 2, own_b: 1'b0, data: mm[a_addr]});
            last_b    = 1'b0;
            last_addr = a_addr;
            if (cnt_a < 65535) cnt_a++;
        end else if (eb) begin
            if (b_wr) mm[b_addr] = b_wdata;
            else rq.push_back('{due: cyc + 2, own_b: 1'b1, data: mm[b_addr]});
            last_b    = 1'b1;
            last_addr = b_addr;
            if (cnt_b < 65535) cnt_b++;
        end
        cyc++;
        #1;
        if (ea || !a_valid) begin
            if (auto_mode) rand_a();
            else a_valid = 1'b0;
        end
        if (eb || !b_valid) begin
            if (auto_mode) rand_b();
            else b_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (n) step();
    endtask

    // Asserts reset away from the clock edge, checks the reset values, and releases it
    // just after a rising edge so the next step() observes the single INIT cycle.
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        rq.delete();
        for (int i = 0; i < (1 << AW); i++) mm[i] = '0;
        last_b    = 1'b1;
        last_addr = '0;
        exp_ard   = '0;
        exp_brd   = '0;
        cnt_a     = 0;
        cnt_b     = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_mem_rst", mem_rst, 1'b1);
        check_eq("rst_mem_wr", mem_wr, 1'b0);
        check_eq("rst_mem_addrs", mem_addrs, 0);
        check_eq("rst_mem_din", mem_din, 0);
        check_eq("rst_a_rvalid", a_rvalid, 1'b0);
        check_eq("rst_b_rvalid", b_rvalid, 1'b0);
        check_eq("rst_a_rdata", a_rdata, 0);
        check_eq("rst_b_rdata", b_rdata, 0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        init_cyc = 1'b1;
    endtask

    task automatic req_a(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a_valid = 1'b1;
        a_wr    = wr;
        a_addr  = addr;
        a_wdata = data;
    endtask

    task automatic req_b(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        b_valid = 1'b1;
        b_wr    = wr;
        b_addr  = addr;
        b_wdata = data;
    endtask

    initial begin
        do_reset();

        // INIT cycle with a request already pending: it must not be granted yet.
        req_a(1'b0, 3'd0, 4'h0);
        step();
        for (int i = 0; i < (1 << AW); i++) begin
            req_a(1'b0, i[AW-1:0], 4'h0);
            step();
        end
        idle(3);

        // Write then read back on A.
        req_a(1'b1, 3'd3, 4'hA);
        step();
        req_a(1'b0, 3'd3, 4'h0);
        step();
        idle(3);
        check_eq("wr_rd_a3", a_rdata, 4'hA);

        // Preload via B, then both clients read continuously: A,B,A,B with no bubbles.
        req_b(1'b1, 3'd1, 4'h5);
        step();
        req_b(1'b1, 3'd2, 4'h6);
        step();
        for (int k = 0; k < 4; k++) begin
            req_a(1'b0, 3'd1, 4'h0);
            req_b(1'b0, 3'd2, 4'h0);
            step();
        end
        idle(3);
        check_eq("alt_a_rdata", a_rdata, 4'h5);
        check_eq("alt_b_rdata", b_rdata, 4'h6);

        // Same-cycle conflict after a B grant: A's write goes first, B reads the new value.
        req_a(1'b1, 3'd7, 4'hF);
        req_b(1'b0, 3'd7, 4'h0);
        step();
        step();
        idle(3);
        check_eq("conflict_b_rdata", b_rdata, 4'hF);

        // Randomized traffic against the model.
        auto_mode = 1'b1;
        rand_a();
        rand_b();
        repeat (400) step();
        auto_mode = 1'b0;
        idle(4);

        // Reset while an A read is in flight: no response, memory cleared again.
        req_a(1'b1, 3'd3, 4'h9);
        step();
        req_a(1'b0, 3'd3, 4'h0);
        step();
        do_reset();
        step();
        req_a(1'b0, 3'd3, 4'h0);
        step();
        idle(3);
        check_eq("post_reset_a3", a_rdata, 4'h0);

`ifdef SRAM_ARB_PERF_EN
        do_reset();
        step();
        for (int i = 0; i < 5; i++) begin
            req_a(1'b0, i[AW-1:0], 4'h0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            req_b(1'b1, i[AW-1:0], 4'h1);
            step();
        end
        idle(2);
        check_eq("perf_a_5", a_grant_cnt, 5);
        check_eq("perf_b_3", b_grant_cnt, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
